// File: rtl/apb_requester_pkg.sv
// Shared types and constants for the APB4 requester.
package apb_requester_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  localparam logic [2:0] APB_PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb_requester.sv
// Single-outstanding APB4 requester: turns one command into one APB transfer and
// returns one response, with an optional ACCESS-phase wait timeout.
module apb_requester
  import apb_requester_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  output logic [2:0]            pprot,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int unsigned CntWidth = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [CntWidth-1:0] CntMax  = '1;

  state_e              state_q;
  logic [CntWidth-1:0] cnt_q;

  assign cmd_ready = (state_q == StIdle);
  assign pprot     = APB_PPROT_DEFAULT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            paddr   <= cmd_addr;
            pwrite  <= cmd_write;
            pwdata  <= cmd_wdata;
            pstrb   <= cmd_write ? cmd_strb : 4'b0000;
            psel    <= 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          penable <= 1'b1;
          cnt_q   <= '0;
          state_q <= StAccess;
        end
        StAccess: begin
          if (pready) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? 32'h0 : prdata;
            rsp_slverr  <= pslverr;
            rsp_timeout <= 1'b0;
            state_q     <= StResp;
          end else if (TIMEOUT_CYCLES != 0 && cnt_q == CntLast) begin
            // This wait cycle is the last one allowed: abandon the transfer.
            cnt_q       <= cnt_q + 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= 32'h0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            state_q     <= StResp;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Directed and randomized checks of apb_requester against a transaction-level
// expectation model (timeout after TO wait cycles, read data only on reads).
module tb_apb_requester;

  localparam int AW = 11;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic          cmd_write = 1'b0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_strb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic [31:0]   prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_requester #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_write  (cmd_write),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pprot      (pprot),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  // One command end to end. waits = ACCESS cycles with pready=0 before pready=1;
  // hold = cycles rsp_ready stays low; pend keeps a second command waiting meanwhile.
  task automatic test_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st, input int waits, input logic [31:0] rd,
                           input logic err, input int hold, input logic pend);
    logic        to;
    int          n_acc;
    logic [3:0]  exp_st;
    logic [31:0] exp_rd;
    logic        exp_err;
    to      = (waits >= TO);
    n_acc   = to ? TO : waits + 1;
    exp_st  = wr ? st : 4'h0;
    exp_rd  = (to || wr) ? 32'h0 : rd;
    exp_err = to || err;

    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_ready: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_wdata = wd;
    cmd_strb  = st;
    @(posedge clk); #1;
    if (pend) begin
      cmd_addr  = ~addr;
      cmd_write = ~wr;
      cmd_wdata = ~wd;
      cmd_strb  = ~st;
    end else begin
      cmd_valid = 1'b0;
    end

    n_cmp++;
    if ({psel, penable, cmd_ready, paddr, pwrite, pwdata, pstrb, pprot} !==
        {1'b1, 1'b0, 1'b0, addr, wr, wd, exp_st, 3'b000}) begin
      n_err++;
      $display("FAIL setup: got sel=%b en=%b rdy=%b a=%h w=%b d=%h s=%h p=%h want a=%h w=%b d=%h s=%h",
               psel, penable, cmd_ready, paddr, pwrite, pwdata, pstrb, pprot,
               addr, wr, wd, exp_st);
    end
    @(posedge clk); #1;

    for (int i = 0; i < n_acc; i++) begin
      n_cmp++;
      if ({psel, penable, rsp_valid, paddr, pwrite, pwdata, pstrb} !==
          {1'b1, 1'b1, 1'b0, addr, wr, wd, exp_st}) begin
        n_err++;
        $display("FAIL access[%0d]: got sel=%b en=%b rv=%b a=%h w=%b d=%h s=%h want 1 1 0 %h %b %h %h",
                 i, psel, penable, rsp_valid, paddr, pwrite, pwdata, pstrb,
                 addr, wr, wd, exp_st);
      end
      pready  = (i == waits);
      prdata  = (i == waits) ? rd : $urandom;
      pslverr = (i == waits) ? err : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    pready  = 1'b0;
    pslverr = 1'b0;

    for (int h = 0; h <= hold; h++) begin
      n_cmp++;
      if ({psel, penable, cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, paddr, pwdata}
          !== {1'b0, 1'b0, 1'b0, 1'b1, exp_rd, exp_err, to, addr, wd}) begin
        n_err++;
        $display("FAIL resp[%0d]: got sel=%b en=%b crdy=%b rv=%b rd=%h err=%b to=%b a=%h d=%h want rd=%h err=%b to=%b",
                 h, psel, penable, cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
                 paddr, pwdata, exp_rd, exp_err, to);
      end
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end

    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, cmd_ready, psel, penable} !== 4'b0100) begin
      n_err++;
      $display("FAIL handshake: got rv=%b crdy=%b sel=%b en=%b want 0 1 0 0",
               rsp_valid, cmd_ready, psel, penable);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_slverr,
         rsp_timeout, pprot} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got sel=%b en=%b w=%b a=%h d=%h s=%h rv=%b rd=%h want all 0",
               psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({cmd_ready, psel} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: got crdy=%b sel=%b want 1 0", cmd_ready, psel);
    end
  endtask

  task automatic test_write();
    test_xfer(11'h010, 1'b1, 32'hA5A5_0F0F, 4'hF, 0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
  endtask

  task automatic test_wait_read();
    test_xfer(11'h200, 1'b0, 32'h0BAD_F00D, 4'hF, 3, 32'h1234_5678, 1'b0, 0, 1'b0);
  endtask

  task automatic test_slverr();
    test_xfer(11'h044, 1'b0, 32'h0, 4'h3, 1, 32'hDEAD_BEEF, 1'b1, 1, 1'b0);
  endtask

  task automatic test_timeout();
    test_xfer(11'h3FC, 1'b0, 32'h0, 4'h0, 100, 32'hCAFE_0001, 1'b0, 0, 1'b0);
    test_xfer(11'h3F8, 1'b0, 32'h0, 4'h0, TO - 1, 32'hCAFE_0002, 1'b0, 0, 1'b0);
    test_xfer(11'h3F4, 1'b1, 32'h5555_AAAA, 4'h6, 100, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_xfer(11'h123, 1'b1, 32'h1111_2222, 4'h9, 0, 32'h0, 1'b0, 5, 1'b1);
    test_xfer(11'h124, 1'b0, 32'h0, 4'hF, 0, 32'h3333_4444, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1;
    cmd_addr  = 11'h0AA;
    cmd_write = 1'b1;
    cmd_wdata = 32'h7777_8888;
    cmd_strb  = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    pready    = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({psel, penable} !== 2'b11) begin
      n_err++;
      $display("FAIL pre_reset_access: got sel=%b en=%b want 1 1", psel, penable);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({psel, penable, rsp_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset: got sel=%b en=%b rv=%b want 0 0 0", psel, penable, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
        n_err++;
        $display("FAIL post_reset: got crdy=%b sel=%b rv=%b want 1 0 0", cmd_ready, psel, rsp_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      test_xfer(AW'($urandom), 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                int'($urandom_range(0, 6)), $urandom, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning APB address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning maximum ACCESS-phase wait cycles; 0 disables timeout.
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid input 1, cmd_ready output 1: command handshake.
REQ-006 SHALL have ports cmd_addr input ADDR_WIDTH, cmd_write input 1, cmd_wdata input 32, cmd_strb input 4: command payload.
REQ-007 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-008 SHALL have ports rsp_rdata output 32, rsp_slverr output 1, rsp_timeout output 1: response payload.
REQ-009 SHALL have APB4 requester ports psel, penable, pwrite output 1; paddr output ADDR_WIDTH; pwdata output 32; pstrb output 4; pprot output 3.
REQ-010 SHALL have APB4 return ports prdata input 32, pready input 1, pslverr input 1.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-012 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid=1 and cmd_ready=1.
REQ-013 On acceptance, the payload SHALL be registered and the FSM SHALL go IDLE->SETUP.
REQ-014 In SETUP: psel=1, penable=0, for exactly one cycle, then SETUP->ACCESS.
REQ-015 In ACCESS: psel=1, penable=1; on pready=1, prdata/pslverr SHALL be captured and the FSM SHALL go ACCESS->RESP.
REQ-016 paddr, pwrite, pwdata and pstrb SHALL be stable from SETUP through the last ACCESS cycle.
REQ-017 pstrb SHALL be 4'b0000 for reads; pprot SHALL be 3'b000 always.
REQ-018 Outside SETUP/ACCESS: psel=0, penable=0; paddr/pwrite/pwdata/pstrb SHALL hold their last values.
REQ-019 A wait counter SHALL clear on SETUP->ACCESS and increment each ACCESS cycle with pready=0.
REQ-020 When TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with pready still 0, the transfer SHALL be abandoned: go to RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
REQ-021 A pready=1 arriving in the same cycle the counter reaches its limit SHALL complete normally (no timeout).
REQ-022 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1; the counter SHALL never wrap.
REQ-023 In RESP, rsp_valid=1 with stable payload until rsp_ready=1, then RESP->IDLE.
REQ-024 rsp_rdata SHALL be 0 for writes; for reads it SHALL be captured prdata, including when pslverr=1.
REQ-025 Zero-wait latency: command accepted at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3; next acceptance no earlier than the cycle after the rsp handshake.
REQ-026 cmd_valid while not in IDLE SHALL be ignored and the command left pending.

Reset
REQ-027 On rst_n=0 the state SHALL go to IDLE immediately; psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout and the counter SHALL be 0; cmd_ready SHALL be 1 after release.
REQ-028 Reset asserted mid-transfer SHALL drop psel/penable asynchronously; no response is generated for the aborted command.

Structure
REQ-029 Package apb_requester_pkg SHALL hold the FSM state enum typedef and the APB_PPROT_DEFAULT constant (3'b000).
REQ-030 The block SHALL be a single module; no sub-module is needed.

Verification
REQ-031 Write addr=0x010, wdata=0xA5A5_0F0F, strb=0xF, pready=1 at first ACCESS -> APB write seen, rsp_valid at N+3, rsp_rdata=0, slverr=0.
REQ-032 Read addr=0x200, completer inserts 3 wait states, prdata=0x1234_5678 -> pstrb=0 throughout, response rdata=0x1234_5678 after 3 extra ACCESS cycles.
REQ-033 Read with pslverr=1, prdata=0xDEAD_BEEF -> rsp_slverr=1, rsp_timeout=0, rdata=0xDEAD_BEEF.
REQ-034 TIMEOUT_CYCLES=4, pready held 0 -> psel drops after 4 wait cycles, rsp_slverr=1, rsp_timeout=1, rdata=0; a further variant with pready=1 on the 4th wait cycle completes normally.
REQ-035 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp payload stable, cmd_ready=0, no new APB transfer until the response handshake.
REQ-036 rst_n pulsed low during ACCESS -> psel/penable=0 in the same cycle, rsp_valid stays 0, cmd_ready=1 after release.
